// File: rtl/zx_mem_pkg.sv
// Shared types for the ZX memory arbiter: read-port owner tags and the
// fixed memory read latency.
package zx_mem_pkg;

  localparam int RD_LAT = 2;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VID};

endpackage

// File: rtl/zx_rd_tag_pipe.sv
// Owner-tag shift register that mirrors the memory read latency, so the tag
// leaving the last stage lines up with the byte on mem_q.
module zx_rd_tag_pipe
  import zx_mem_pkg::*;
#(
  parameter int STAGES = RD_LAT
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [STAGES];
  rd_tag_t stage_d [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = TAG_NONE;
    end
    if (!clr) begin
      stage_d[0] = tag_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/zx_mem_arbiter.sv
// Shares one dual-port memory between the video fetcher and the CPU: video
// has read priority with a CPU starvation guard, CPU writes use the write port.
module zx_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 2,
  parameter int WAIT_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr_wr,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic              mem_wren
);

  import zx_mem_pkg::*;

  localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic              cpu_rd;
  logic              cpu_wr;
  logic              force_cpu;
  logic              grant_vid;
  logic              grant_cpu;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [DATA_W-1:0] data_wr_q, data_wr_d;
  rd_tag_t           issue_tag;
  rd_tag_t           resp_tag;

  // Starvation guard: once the CPU has lost WAIT_MAX slots it takes the port.
  always_comb begin
    cpu_rd    = cpu_req & ~cpu_we;
    cpu_wr    = cpu_req & cpu_we;
    force_cpu = cpu_rd & (wait_cnt_q == WAIT_LIM);
    grant_vid = ~rst & vid_req & ~force_cpu;
    grant_cpu = ~rst & cpu_rd & ~grant_vid;
    vid_ack   = grant_vid;
    cpu_ack   = grant_cpu | (~rst & cpu_wr);

    issue_tag.valid = grant_vid | grant_cpu;
    issue_tag.owner = grant_cpu ? OWN_CPU : OWN_VID;
  end

  always_comb begin
    wait_cnt_d = '0;
    if (!rst && cpu_rd && !grant_cpu) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Address/data outputs hold their last granted value when idle.
  always_comb begin
    addr_rd_d = addr_rd_q;
    addr_wr_d = addr_wr_q;
    data_wr_d = data_wr_q;
    if (grant_vid) begin
      addr_rd_d = vid_addr;
    end else if (grant_cpu) begin
      addr_rd_d = cpu_addr;
    end
    if (cpu_wr) begin
      addr_wr_d = cpu_addr;
      data_wr_d = cpu_wdata;
    end
    if (rst) begin
      addr_rd_d = '0;
      addr_wr_d = '0;
      data_wr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    wait_cnt_q <= wait_cnt_d;
    addr_rd_q  <= addr_rd_d;
    addr_wr_q  <= addr_wr_d;
    data_wr_q  <= data_wr_d;
  end

  assign mem_addr_rd = addr_rd_d;
  assign mem_addr_wr = addr_wr_d;
  assign mem_data_wr = data_wr_d;
  assign mem_wren    = ~rst & cpu_wr;

  zx_rd_tag_pipe #(
    .STAGES (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (issue_tag),
    .tag_out (resp_tag)
  );

  // In-flight responses are suppressed while rst is high.
  always_comb begin
    vid_rvalid = ~rst & resp_tag.valid & (resp_tag.owner == OWN_VID);
    cpu_rvalid = ~rst & resp_tag.valid & (resp_tag.owner == OWN_CPU);
    vid_rdata  = vid_rvalid ? mem_q : '0;
    cpu_rdata  = cpu_rvalid ? mem_q : '0;
  end

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Self-checking bench for zx_mem_arbiter: a behavioural 2-cycle memory, a
// reference copy of memory contents and a response scoreboard.
module tb_zx_mem_arbiter;

  import zx_mem_pkg::*;

  typedef struct {
    int          due;
    owner_e      owner;
    logic [7:0]  data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic        vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr_rd;
  logic [7:0]  mem_q;
  logic [15:0] mem_addr_wr;
  logic [7:0]  mem_data_wr;
  logic        mem_wren;

  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  rd_pipe1;
  logic [7:0]  rd_pipe2;

  exp_t        sb [$];
  exp_t        e;
  int          cyc;
  int          errors;
  int          checks;

  zx_mem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (8),
    .RD_LAT   (2),
    .WAIT_MAX (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_ack     (vid_ack),
    .vid_rvalid  (vid_rvalid),
    .vid_rdata   (vid_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_addr_rd (mem_addr_rd),
    .mem_q       (mem_q),
    .mem_addr_wr (mem_addr_wr),
    .mem_data_wr (mem_data_wr),
    .mem_wren    (mem_wren)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: the read samples contents before a same-edge write lands,
  // then the byte travels through two registers to mem_q.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr_wr] <= mem_data_wr;
    rd_pipe1 <= mem[mem_addr_rd];
    rd_pipe2 <= rd_pipe1;
  end
  assign mem_q = rd_pipe2;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and return at the
  // following falling edge, where outputs are stable for sampling.
  task automatic applyStimulus(input logic r, input logic vr, input logic [15:0] va,
                               input logic cr, input logic cw, input logic [15:0] ca,
                               input logic [7:0] cd);
    @(posedge clk);
    #1;
    rst       = r;
    vid_req   = vr;
    vid_addr  = va;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  // Scoreboard monitor: compares returning data against what the reference
  // memory held when each read was accepted, then records this cycle's grants.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      checkOutput("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      checkOutput("rst_acks", 32'({vid_ack, cpu_ack}), 32'd0);
      checkOutput("rst_mem_wren", 32'(mem_wren), 32'd0);
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checkOutput("rsp_missing_due", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checkOutput("rsp_vid_rvalid", 32'(vid_rvalid), 32'(e.owner == OWN_VID));
        checkOutput("rsp_cpu_rvalid", 32'(cpu_rvalid), 32'(e.owner == OWN_CPU));
        if (e.owner == OWN_VID) checkOutput("rsp_vid_rdata", 32'(vid_rdata), 32'(e.data));
        else                    checkOutput("rsp_cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end else begin
        checkOutput("idle_rvalids", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
      end
      checkOutput("mem_wren", 32'(mem_wren), 32'(cpu_req && cpu_we));
      if (cpu_req && cpu_we) checkOutput("cpu_wr_ack", 32'(cpu_ack), 32'd1);
      if (vid_req && vid_ack)
        sb.push_back('{due: cyc + 2, owner: OWN_VID, data: ref_mem[vid_addr]});
      if (cpu_req && !cpu_we && cpu_ack)
        sb.push_back('{due: cyc + 2, owner: OWN_CPU, data: ref_mem[cpu_addr]});
      if (cpu_req && cpu_we && cpu_ack)
        ref_mem[cpu_addr] = cpu_wdata;
    end
    cyc++;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence following the test plan, then a short random mix.
  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     <= 8'(i[7:0] ^ i[15:8]);
      ref_mem[i]  = 8'(i[7:0] ^ i[15:8]);
    end
    mem[16'h4000]     <= 8'hA5;
    ref_mem[16'h4000]  = 8'hA5;

    rst       = 1'b1;
    vid_req   = 1'b1;
    vid_addr  = 16'h4000;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h1234;
    cpu_wdata = 8'hEE;

    // Reset with requests asserted: nothing may be acked or written.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h4000, 1'b1, 1'b1, 16'h1234, 8'hEE);
      checkOutput("reset_vid_ack", 32'(vid_ack), 32'd0);
      checkOutput("reset_cpu_ack", 32'(cpu_ack), 32'd0);
      checkOutput("reset_mem_addr_rd", 32'(mem_addr_rd), 32'd0);
      checkOutput("reset_mem_addr_wr", 32'(mem_addr_wr), 32'd0);
      checkOutput("reset_mem_data_wr", 32'(mem_data_wr), 32'd0);
      checkOutput("reset_rdata", 32'({vid_rdata, cpu_rdata}), 32'd0);
    end
    idleCycle();

    $display("[TB] video read of 0x4000");
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h0, 8'h0);
    checkOutput("vrd_vid_ack", 32'(vid_ack), 32'd1);
    checkOutput("vrd_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("vrd_mem_addr_rd", 32'(mem_addr_rd), 32'h4000);
    idleCycle();
    checkOutput("vrd_early_rvalid", 32'(vid_rvalid), 32'd0);
    idleCycle();
    checkOutput("vrd_vid_rvalid", 32'(vid_rvalid), 32'd1);
    checkOutput("vrd_vid_rdata", 32'(vid_rdata), 32'hA5);
    checkOutput("vrd_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    idleCycle();
    checkOutput("vrd_one_cycle", 32'(vid_rvalid), 32'd0);

    $display("[TB] video read plus CPU write, then CPU read-after-write");
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 8'h5C);
    checkOutput("vw_vid_ack", 32'(vid_ack), 32'd1);
    checkOutput("vw_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("vw_mem_wren", 32'(mem_wren), 32'd1);
    checkOutput("vw_mem_addr_wr", 32'(mem_addr_wr), 32'h1234);
    checkOutput("vw_mem_data_wr", 32'(mem_data_wr), 32'h5C);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h1234, 8'h0);
    checkOutput("raw_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("raw_mem_wren", 32'(mem_wren), 32'd0);
    idleCycle();
    checkOutput("old_vid_rvalid", 32'(vid_rvalid), 32'd1);
    checkOutput("old_vid_rdata", 32'(vid_rdata), 32'h26);
    idleCycle();
    checkOutput("new_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    checkOutput("new_cpu_rdata", 32'(cpu_rdata), 32'h5C);
    idleCycle();

    $display("[TB] continuous video with a pending CPU read");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h4000 + 16'(i), 1'b1, 1'b0, 16'h1234, 8'h0);
      checkOutput("starve_cpu_ack", 32'(cpu_ack), 32'((i % 4) == 3));
      checkOutput("starve_vid_ack", 32'(vid_ack), 32'((i % 4) != 3));
    end
    for (int i = 0; i < 3; i++) idleCycle();

    $display("[TB] reset with two reads in flight");
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h1234, 8'h0);
    checkOutput("inflight_a_vid_ack", 32'(vid_ack), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h4001, 1'b1, 1'b0, 16'h1234, 8'h0);
    checkOutput("inflight_b_vid_ack", 32'(vid_ack), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h4002, 1'b1, 1'b0, 16'h1234, 8'h0);
    checkOutput("midrst_rvalids", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
    checkOutput("midrst_mem_addr_rd", 32'(mem_addr_rd), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h4010 + 16'(i), 1'b1, 1'b0, 16'h1234, 8'h0);
      if (i == 0) checkOutput("postrst_rvalids", 32'({vid_rvalid, cpu_rvalid}), 32'd0);
      checkOutput("postrst_cpu_ack", 32'(cpu_ack), 32'(i == 3));
      checkOutput("postrst_vid_ack", 32'(vid_ack), 32'(i != 3));
    end
    for (int i = 0; i < 3; i++) idleCycle();

    $display("[TB] random mix of requests");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'h1230 + 16'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'h1230 + 16'($urandom_range(0, 7)), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) idleCycle();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zx_mem_arbiter.md
# zx_mem_arbiter

Arbitrates one shared 64K×8 dual-port memory between the video fetcher and the CPU. Video and CPU reads share the memory's single read port; CPU writes go to the independent write port. The block tracks the memory's fixed 2-cycle read latency with an owner-tagged pipeline and routes each returned byte to the requester that issued it. It sits between the ZX80 core and video generator and the memory model or RAM.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- RD_LAT, 2, memory read latency in cycles; fixed at 2, other values unsupported
- WAIT_MAX, 3, maximum cycles a pending CPU read may lose to video before it is forced through

Ports:
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_ack  out  1  video request accepted this cycle
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  DATA_W  video read data
- cpu_req  in  1  CPU request
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data
- mem_addr_rd  out  ADDR_W  memory read address
- mem_q  in  DATA_W  memory read data, RD_LAT cycles after mem_addr_rd
- mem_addr_wr  out  ADDR_W  memory write address
- mem_data_wr  out  DATA_W  memory write data
- mem_wren  out  1  memory write enable

## Operation
- Handshake: a request is accepted in a cycle when req=1 and ack=1 in that same cycle. ack is combinational from req and registered state. The requester holds req, addr and data until it sees ack. Back-to-back requests are accepted one per cycle.
- CPU write (cpu_req & cpu_we): always acked in the same cycle. mem_wren=1, mem_addr_wr=cpu_addr, mem_data_wr=cpu_wdata. Never conflicts with reads.
- Read port arbitration: video has fixed priority, overridden by the starvation guard.
  - cpu_rd = cpu_req & ~cpu_we.
  - If cpu_rd and wait_cnt == WAIT_MAX, the CPU is granted the read port and vid_ack=0.
  - Otherwise, if vid_req, video is granted.
  - Otherwise, if cpu_rd, the CPU is granted.
  - mem_addr_rd = the granted address. It holds its last value when idle; it is 0 after reset.
- wait_cnt, saturating at WAIT_MAX:
  - +1 each cycle cpu_rd=1 and cpu_ack=0.
  - Cleared on a CPU read ack, or when cpu_rd=0.
- Tag pipeline: two stages, each {valid, owner}, owner ∈ {VID, CPU}.
  - Stage 1 loads the grant of this cycle.
  - Stage 2 loads stage 1.
  - Stage 2 valid with owner X drives X_rvalid=1 and X_rdata=mem_q.
- Read data reflects memory content at the issue cycle. A CPU write in the issue cycle or later is not seen by that read; a write in an earlier cycle is seen.
- Reset values: all acks, rvalids and mem_wren are 0; tags are invalid; wait_cnt=0; mem_addr_rd, mem_addr_wr, mem_data_wr and rdata are 0.

## Timing
- Read accepted in cycle t: rvalid=1 with data in cycle t+2, for exactly 1 cycle.
- Up to 2 reads in flight. Responses return in issue order. At most one rvalid is high per cycle.
- Write accepted in cycle t: the memory is updated at the end of t. A read issued at t+1 returns the new data at t+3.
- Simultaneous video read and CPU write: both are acked in the same cycle.
- Continuous vid_req with a pending CPU read: the CPU is acked on the (WAIT_MAX+1)-th cycle of waiting. With WAIT_MAX=3, video loses 1 slot in every 4.
- rst asserted mid-operation: at the next edge the tags clear, in-flight reads are dropped with no rvalid, and wait_cnt=0. Acks are 0 during every cycle rst=1. mem_wren is forced to 0 while rst=1.

## Structure
- Package zx_mem_pkg holds:
  - owner enum {OWN_VID, OWN_CPU};
  - the tag struct {valid, owner};
  - the RD_LAT constant (2).
- Sub-module zx_rd_tag_pipe: a 2-stage tag shift register with synchronous clear. The arbiter top instantiates it once.
- The arbiter top holds the grant logic, wait_cnt, write-port drive and response demux.

## Test plan
- Video read at 0x4000 (memory holds 0xA5) in cycle 0 -> vid_ack=1 in cycle 0; vid_rvalid=1, vid_rdata=0xA5 in cycle 2; cpu_rvalid stays 0.
- CPU write 0x5C to 0x1234 in cycle 0, CPU read 0x1234 in cycle 1 -> cpu_rdata=0x5C in cycle 3. A read of 0x1234 issued in cycle 0 returns the old value.
- vid_req held for 12 cycles with cpu_rd also held, WAIT_MAX=3 -> cpu_ack in cycles 3, 7 and 11 only; vid_ack in all other cycles; response owners match the grant order.
- Video read and CPU write in the same cycle -> both acked; mem_wren=1; the video data returns 2 cycles later, unaffected.
- Two reads in flight (cycles 5 and 6), rst=1 in cycle 7 -> no rvalid in cycles 7 or 8, all outputs at reset values, wait_cnt=0.
